// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for mux_4to1: holds each enabled channel for D cycles, captures y on the last dwell cycle.
// Latency: sample_valid N*D edges after start; no backpressure (sample is overwritten each sweep, stop aborts at the next edge).
module mux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [3:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s0,
  output logic               s1,
  output logic [3:0]         sample,
  output logic               sample_valid,
  output logic               busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         en_q, en_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         sample_q, sample_d;
  logic               sv_q, sv_d;
  logic [3:0]         cap;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_ch = 2'(i);
    end
  endfunction

  // Closest enabled channel strictly above c; has_next_ch says whether one exists.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
    next_ch = c;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) next_ch = 2'(i);
    end
  endfunction

  function automatic logic has_next_ch(input logic [3:0] m, input logic [1:0] c);
    has_next_ch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (i > int'(c))) has_next_ch = 1'b1;
    end
  endfunction

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    eff_dwell = (d == '0) ? DWELL_W'(1) : d;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    en_d     = en_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    sv_d     = 1'b0;
    cap      = shadow_q;
    cap[sel_q] = y;

    case (state_q)
      IDLE: begin
        if (start && !stop && (ch_en != 4'b0)) begin
          en_d     = ch_en;
          dwell_d  = eff_dwell(dwell);
          cnt_d    = eff_dwell(dwell);
          sel_d    = lowest_ch(ch_en);
          shadow_d = 4'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          shadow_d = cap;
          if (has_next_ch(en_q, sel_q)) begin
            sel_d = next_ch(en_q, sel_q);
            cnt_d = dwell_q;
          end else begin
            // Sweep complete: publish, then either re-arm from fresh inputs or fall back to IDLE.
            sample_d = cap & en_q;
            sv_d     = 1'b1;
            shadow_d = 4'b0;
            if (continuous && (ch_en != 4'b0)) begin
              en_d    = ch_en;
              dwell_d = eff_dwell(dwell);
              cnt_d   = eff_dwell(dwell);
              sel_d   = lowest_ch(ch_en);
            end else begin
              state_d = IDLE;
              sel_d   = 2'd0;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      en_q     <= 4'b0;
      shadow_q <= 4'b0;
      sample_q <= 4'b0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      en_q     <= en_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
    end
  end

  assign s0           = sel_q[0];
  assign s1           = sel_q[1];
  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign busy         = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural mux_4to1 closing the y loop.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, continuous;
  logic [3:0] ch_en;
  logic [7:0] dwell;
  logic [3:0] mux_in;
  logic       y, s0, s1, sample_valid, busy;
  logic [3:0] sample;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y = mux_in[{s1, s0}];

  mux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .ch_en(ch_en), .dwell(dwell), .y(y), .s0(s0), .s1(s1),
    .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  typedef struct {
    logic       rst, start, stop, cont;
    logic [3:0] ch_en;
    logic [7:0] dwell;
    logic [3:0] mux_in;
    logic [1:0] e_sel;
    logic [3:0] e_sample;
    logic       e_sv, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, st, sp, c, input logic [3:0] en, input logic [7:0] d,
                   input logic [3:0] m, input logic [1:0] es, input logic [3:0] esm,
                   input logic esv, eb);
    vec_t t;
    t.rst = r; t.start = st; t.stop = sp; t.cont = c; t.ch_en = en; t.dwell = d;
    t.mux_in = m; t.e_sel = es; t.e_sample = esm; t.e_sv = esv; t.e_busy = eb;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] es, input logic [3:0] esm,
                         input logic esv, input logic eb);
    chk({tag, ".sel"}, {6'd0, s1, s0}, {6'd0, es});
    chk({tag, ".sample"}, {4'd0, sample}, {4'd0, esm});
    chk({tag, ".valid"}, {7'd0, sample_valid}, {7'd0, esv});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_en = 4'b0; dwell = 8'd0; mux_in = 4'b0;

    // Full sweep, dwell 2, inputs i0..i3 = 1,0,1,0
    v(1,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd0, 4'b0000, 0, 0);
    v(0,1,0,0, 4'b1111, 8'd2, 4'b0101, 2'd0, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd0, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd1, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd1, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd2, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd2, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd3, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd3, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd0, 4'b0101, 1, 0);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b0101, 2'd0, 4'b0101, 0, 0);
    // Masked sweep, dwell 0 behaves as 1
    v(0,1,0,0, 4'b1010, 8'd0, 4'b0101, 2'd1, 4'b0101, 0, 1);
    v(0,0,0,0, 4'b1010, 8'd0, 4'b0101, 2'd3, 4'b0101, 0, 1);
    v(0,0,0,0, 4'b1010, 8'd0, 4'b0101, 2'd0, 4'b0000, 1, 0);
    v(0,1,0,0, 4'b1010, 8'd0, 4'b1010, 2'd1, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1010, 8'd0, 4'b1010, 2'd3, 4'b0000, 0, 1);
    v(0,0,0,0, 4'b1010, 8'd0, 4'b1010, 2'd0, 4'b1010, 1, 0);
    v(0,0,0,0, 4'b1010, 8'd0, 4'b1010, 2'd0, 4'b1010, 0, 0);
    // Ignored starts: empty mask, and stop beating start
    v(0,1,0,0, 4'b0000, 8'd2, 4'b1010, 2'd0, 4'b1010, 0, 0);
    v(0,1,1,0, 4'b1111, 8'd2, 4'b1010, 2'd0, 4'b1010, 0, 0);
    // Reset mid-sweep clears everything
    v(0,1,0,0, 4'b1111, 8'd2, 4'b1010, 2'd0, 4'b1010, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b1010, 2'd0, 4'b1010, 0, 1);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b1010, 2'd1, 4'b1010, 0, 1);
    v(1,0,0,0, 4'b1111, 8'd2, 4'b1010, 2'd0, 4'b0000, 0, 0);
    v(0,0,0,0, 4'b1111, 8'd2, 4'b1010, 2'd0, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      continuous = vecs[i].cont; ch_en = vecs[i].ch_en; dwell = vecs[i].dwell;
      mux_in = vecs[i].mux_in;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_sample, vecs[i].e_sv, vecs[i].e_busy);
    end
    rst = 1'b0; start = 1'b0;

    // Continuous: 12-cycle period, no gap, sample[0] tracks i0, clearing continuous ends after the sweep
    ch_en = 4'b1111; dwell = 8'd3; mux_in = 4'b0101; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int sw = 0; sw < 3; sw++) begin
      for (int k = 1; k <= 12; k++) begin
        step();
        chk($sformatf("cont%0d.valid%0d", sw, k), {7'd0, sample_valid}, {7'd0, (k == 12)});
        if (k < 12) chk($sformatf("cont%0d.busy%0d", sw, k), {7'd0, busy}, 8'd1);
      end
      if (sw == 0) begin
        chk("cont0.sample", {4'd0, sample}, 8'h05);
        chk("cont0.busy", {7'd0, busy}, 8'd1);
        mux_in = 4'b0100;
      end else if (sw == 1) begin
        chk("cont1.sample", {4'd0, sample}, 8'h04);
        continuous = 1'b0;
        mux_in = 4'b0101;
      end else begin
        chk("cont2.sample", {4'd0, sample}, 8'h05);
        chk("cont2.busy", {7'd0, busy}, 8'd0);
        chk("cont2.sel", {6'd0, s1, s0}, 8'd0);
      end
    end
    step();
    chk("cont.after.valid", {7'd0, sample_valid}, 8'd0);

    // Abort during channel 2: sample keeps 0101
    ch_en = 4'b1111; dwell = 8'd2; mux_in = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk("abort.pre.sel", {6'd0, s1, s0}, 8'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("abort", 2'd0, 4'b0101, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("abort.quiet%0d", k), {7'd0, sample_valid}, 8'd0);
    end

    // Second start mid-sweep is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      step();
      if (k < 8) begin
        chk($sformatf("busystart.sel%0d", k), {6'd0, s1, s0}, 8'(k / 2));
        chk($sformatf("busystart.valid%0d", k), {7'd0, sample_valid}, 8'd0);
      end
    end
    chk_all("busystart.done", 2'd0, 4'b0011, 1'b1, 1'b0);

    // Maximum dwell on a single channel
    ch_en = 4'b1000; dwell = 8'd255; mux_in = 4'b1000; start = 1'b1;
    step();
    start = 1'b0;
    chk("maxdwell.sel", {6'd0, s1, s0}, 8'd3);
    for (int k = 1; k <= 255; k++) begin
      step();
      if (k >= 250) chk($sformatf("maxdwell.valid%0d", k), {7'd0, sample_valid}, {7'd0, (k == 255)});
      if (k == 254) chk("maxdwell.sel254", {6'd0, s1, s0}, 8'd3);
    end
    chk("maxdwell.sample", {4'd0, sample}, 8'h08);
    chk("maxdwell.busy", {7'd0, busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
